// File: rtl/branch_resolve_unit.sv
// Branch resolver: evaluates RV32I conditional branches, flags mispredicts,
// trains a 2-bit bimodal history table and keeps branch/mispredict statistics.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int PIPE_STAGE  = 1,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [XLEN-1:0]    lookup_pc,
    output logic               lookup_taken,
    input  logic               res_valid,
    input  logic [XLEN-1:0]    res_pc,
    input  logic [2:0]         res_func3,
    input  logic [XLEN-1:0]    res_rs1_data,
    input  logic [XLEN-1:0]    res_rs2_data,
    input  logic               res_pred_taken,
    output logic               out_valid,
    output logic               out_taken,
    output logic               out_mispredict,
    output logic               out_illegal,
    output logic [COUNT_W-1:0] branch_count,
    output logic [COUNT_W-1:0] mispred_count
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] res_idx;
    logic             taken;
    logic             illegal;
    logic             acc;
    logic             legal;
    logic             mispred;

    // PC bits outside the index window only feed this sink.
    logic unused_bits;
    assign unused_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0],
                           res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

    assign lk_idx       = lookup_pc[IDX_W+1:2];
    assign res_idx      = res_pc[IDX_W+1:2];
    assign lookup_taken = bht[lk_idx][1];

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (res_func3)
            3'b000:  taken = (res_rs1_data == res_rs2_data);
            3'b001:  taken = (res_rs1_data != res_rs2_data);
            3'b100:  taken = ($signed(res_rs1_data) <  $signed(res_rs2_data));
            3'b101:  taken = ($signed(res_rs1_data) >= $signed(res_rs2_data));
            3'b110:  taken = (res_rs1_data <  res_rs2_data);
            3'b111:  taken = (res_rs1_data >= res_rs2_data);
            default: illegal = 1'b1;
        endcase
    end

    assign acc     = res_valid & ~flush & ~rst;
    assign legal   = acc & ~illegal;
    assign mispred = legal & (taken != res_pred_taken);

    // Training happens at the request edge in both pipe modes, so lookups see it next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (legal) begin
            if (taken && bht[res_idx] != 2'b11)
                bht[res_idx] <= bht[res_idx] + 2'd1;
            else if (!taken && bht[res_idx] != 2'b00)
                bht[res_idx] <= bht[res_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else begin
            branch_count  <= branch_count  + COUNT_W'(legal);
            mispred_count <= mispred_count + COUNT_W'(mispred);
        end
    end

    if (PIPE_STAGE != 0) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                out_valid      <= 1'b0;
                out_taken      <= 1'b0;
                out_mispredict <= 1'b0;
                out_illegal    <= 1'b0;
            end else begin
                out_valid      <= acc;
                out_taken      <= legal & taken;
                out_mispredict <= mispred;
                out_illegal    <= acc & illegal;
            end
        end
    end else begin : g_comb
        always_comb begin
            out_valid      = acc;
            out_taken      = legal & taken;
            out_mispredict = mispred;
            out_illegal    = acc & illegal;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit (PIPE_STAGE=1, COUNT_W=4 so wrap is reachable).
module tb_branch_resolve_unit;
    localparam int XLEN = 32;
    localparam int NENT = 64;
    localparam int CW   = 4;

    typedef struct packed {
        logic t;
        logic m;
        logic il;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst, flush, res_valid, res_pred_taken;
    logic [XLEN-1:0] lookup_pc, res_pc, res_rs1_data, res_rs2_data;
    logic [2:0]      res_func3;
    logic            lookup_taken, out_valid, out_taken, out_mispredict, out_illegal;
    logic [CW-1:0]   branch_count, mispred_count;

    exp_t     sb[$];
    logic [1:0] bht_m [NENT];
    logic [CW-1:0] bc_m, mc_m;
    logic     last_acc;
    int       n_cmp = 0;
    int       n_err = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(NENT), .PIPE_STAGE(1), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
        .res_valid(res_valid), .res_pc(res_pc), .res_func3(res_func3),
        .res_rs1_data(res_rs1_data), .res_rs2_data(res_rs2_data),
        .res_pred_taken(res_pred_taken),
        .out_valid(out_valid), .out_taken(out_taken), .out_mispredict(out_mispredict),
        .out_illegal(out_illegal), .branch_count(branch_count), .mispred_count(mispred_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) bht_m[i] = 2'b01;
        bc_m = '0;
        mc_m = '0;
        sb.delete();
        last_acc = 1'b0;
    endtask

    // Check output drained from the scoreboard after an edge.
    task automatic check_out(input logic acc);
        exp_t e;
        chk("out_valid", 32'(out_valid), 32'(acc));
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("out_taken", 32'(out_taken), 32'(e.t));
                chk("out_mispredict", 32'(out_mispredict), 32'(e.m));
                chk("out_illegal", 32'(out_illegal), 32'(e.il));
            end
        end else begin
            chk("idle_fields", 32'({out_taken, out_mispredict, out_illegal}), 32'(0));
        end
        chk("branch_count", 32'(branch_count), 32'(bc_m));
        chk("mispred_count", 32'(mispred_count), 32'(mc_m));
    endtask

    task automatic req(input logic v, input logic fl, input logic [31:0] pc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic pred);
        logic acc, il, t;
        exp_t e;
        res_valid = v; flush = fl; res_pc = pc; res_func3 = f3;
        res_rs1_data = a; res_rs2_data = b; res_pred_taken = pred;
        #1;
        // Previous result is still visible before this edge, even when flushing.
        chk("pre_valid", 32'(out_valid), 32'(last_acc));
        acc = v & ~fl;
        il  = (f3 == 3'b010) || (f3 == 3'b011);
        t   = il ? 1'b0 : ref_taken(f3, a, b);
        if (acc) begin
            e.t = t; e.il = il; e.m = ~il & (t != pred);
            sb.push_back(e);
            if (!il) begin
                bc_m++;
                if (t != pred) mc_m++;
                if (t && bht_m[idx(pc)] != 2'b11) bht_m[idx(pc)]++;
                else if (!t && bht_m[idx(pc)] != 2'b00) bht_m[idx(pc)]--;
            end
        end
        @(posedge clk); #1;
        check_out(acc);
        last_acc = acc;
        res_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        res_valid = 1'b0;
        @(posedge clk); #1;
        check_out(1'b0);
        last_acc = 1'b0;
    endtask

    task automatic lk(input string tag, input logic [31:0] pc);
        lookup_pc = pc;
        #1;
        chk(tag, 32'(lookup_taken), 32'(bht_m[idx(pc)][1]));
    endtask

    // Reset with a request present: both the pending result and that request are discarded.
    task automatic do_reset();
        rst = 1'b1;
        res_valid = 1'b1; flush = 1'b0; res_pc = 32'h10; res_func3 = 3'b000;
        res_rs1_data = 32'h0; res_rs2_data = 32'h0; res_pred_taken = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; res_valid = 1'b0;
        model_reset();
        check_out(1'b0);
    endtask

    logic [2:0] f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic       sweep_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; flush = 1'b0; res_valid = 1'b0; res_pc = '0; res_func3 = '0;
        res_rs1_data = '0; res_rs2_data = '0; res_pred_taken = 1'b0; lookup_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1) post-reset state
        lookup_pc = 32'h100; #1;
        chk("rst_lookup", 32'(lookup_taken), 32'(0));
        chk("rst_bcnt", 32'(branch_count), 32'(0));
        chk("rst_mcnt", 32'(mispred_count), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));

        // 2) compare sweep, back-to-back, plus constant cross-check of direction
        for (int i = 0; i < 6; i++) begin
            req(1, 0, 32'h40 + 32'(4 * i), f3s[i], 32'hFFFF_FFFF, 32'h1, 1'b0);
            chk("sweep_dir", 32'(out_taken), 32'(sweep_exp[i]));
        end
        idle();
        for (int i = 0; i < 6; i++) lk("sweep_lk", 32'h40 + 32'(4 * i));

        // random compares, random predictions
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = (i % 3 == 0) ? a : $urandom;
            req(1, 0, $urandom, f3s[$urandom_range(0, 5)], a, b, 1'($urandom));
        end
        idle();

        // 3) BHT training on pc 0x200
        do_reset();
        lookup_pc = 32'h200; #1;
        chk("train0", 32'(lookup_taken), 32'(0));
        req(1, 0, 32'h200, 3'd0, 32'h5, 32'h5, 1'b0);
        lookup_pc = 32'h200; #1;
        chk("train1", 32'(lookup_taken), 32'(1));
        req(1, 0, 32'h200, 3'd0, 32'h5, 32'h5, 1'b0);
        chk("train_mcnt", 32'(mispred_count), 32'(2));
        for (int i = 0; i < 4; i++) req(1, 0, 32'h200, 3'd0, 32'h7, 32'h7, 1'b1);
        req(1, 0, 32'h200, 3'd0, 32'h7, 32'h8, 1'b1);
        lk("sat_lk", 32'h200);
        chk("sat_taken", 32'(lookup_taken), 32'(1));
        req(1, 0, 32'h200, 3'd0, 32'h7, 32'h8, 1'b1);
        lookup_pc = 32'h200; #1;
        chk("untrain", 32'(lookup_taken), 32'(0));

        // 4) aliasing
        req(1, 0, 32'h004, 3'd1, 32'h1, 32'h2, 1'b0);
        lookup_pc = 32'h104; #1;
        chk("alias", 32'(lookup_taken), 32'(1));
        lookup_pc = 32'h008; #1;
        chk("no_alias", 32'(lookup_taken), 32'(0));

        // 5) flush and illegal
        req(1, 0, 32'h20, 3'd0, 32'h1, 32'h1, 1'b0);
        req(1, 1, 32'h20, 3'd0, 32'h1, 32'h1, 1'b0);
        idle();
        req(1, 0, 32'h30, 3'b010, 32'h1, 32'h1, 1'b1);
        chk("ill_flag", 32'(out_illegal), 32'(1));
        req(1, 0, 32'h30, 3'b011, 32'h1, 32'h1, 1'b0);
        lk("ill_lk", 32'h30);
        idle();

        // 6) counter wrap and mid-stream reset
        do_reset();
        for (int i = 0; i < 17; i++) req(1, 0, 32'h10, 3'd0, 32'h3, 32'h3, 1'b1);
        chk("wrap_bcnt", 32'(branch_count), 32'(1));
        lookup_pc = 32'h10; #1;
        chk("wrap_lk", 32'(lookup_taken), 32'(1));
        req(1, 0, 32'h10, 3'd0, 32'h3, 32'h3, 1'b0);
        do_reset();
        chk("rst_pend_valid", 32'(out_valid), 32'(0));
        lookup_pc = 32'h10; #1;
        chk("rst_bht", 32'(lookup_taken), 32'(0));
        idle();
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
